// File: rtl/viterbi_traceback_if.sv
// Traceback unit bus bundle.
// Groups the start request, the survivor-RAM read port and the decoded-bit
// output stream of the traceback unit.
//   master : the environment (issues starts, returns RAM data, consumes bits)
//   slave  : viterbi_traceback
// Signals:
//   TbStart/TbStartStage/TbStartState  start request and walk origin
//   AddressRAM/RAMEnable/RWSelect      survivor RAM read address, enable (low), R/W
//   DataRAM                            survivor RAM read data (one cycle after address)
//   DecodedBit/DecodedValid            decoded output stream, oldest bit first
//   TbBusy/TbDone                      status
interface viterbi_traceback_if;
  logic        TbStart;
  logic [5:0]  TbStartStage;
  logic [7:0]  TbStartState;
  logic [10:0] AddressRAM;
  logic        RAMEnable;
  logic        RWSelect;
  logic [7:0]  DataRAM;
  logic        DecodedBit;
  logic        DecodedValid;
  logic        TbBusy;
  logic        TbDone;

  modport master (
    output TbStart, TbStartStage, TbStartState, DataRAM,
    input  AddressRAM, RAMEnable, RWSelect, DecodedBit, DecodedValid, TbBusy, TbDone
  );

  modport slave (
    input  TbStart, TbStartStage, TbStartState, DataRAM,
    output AddressRAM, RAMEnable, RWSelect, DecodedBit, DecodedValid, TbBusy, TbDone
  );
endinterface

// File: rtl/viterbi_traceback.sv
// Traceback unit for a K=9 (256-state) Viterbi decoder.
// Walks the survivor RAM (2048 x 8, address {stage[5:0], state[7:3]}) backwards
// from a given stage/state for TB_LEN+DEC_LEN stages, discards the first TB_LEN
// decisions, buffers the last DEC_LEN, then emits them oldest-first.
// Ports:
//   i_Clock1  system clock, rising edge
//   i_Reset   asynchronous active-low reset
//   tb        viterbi_traceback_if.slave (start, RAM read port, bit stream, status)
// All outputs are registered and follow the FSM state of the same cycle.
module viterbi_traceback #(
  parameter int TB_LEN  = 48,
  parameter int DEC_LEN = 16
) (
  input  logic                 i_Clock1,
  input  logic                 i_Reset,
  viterbi_traceback_if.slave   tb
);

  localparam int WALK = TB_LEN + DEC_LEN;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_OUT, S_DONE} state_e;

  state_e              r_fsm, w_nxt;
  logic [5:0]          r_stage;
  logic [7:0]          r_state;
  logic [6:0]          r_cnt;
  logic [5:0]          r_idx;
  logic [DEC_LEN-1:0]  r_buf;

  logic [10:0]         r_addr;
  logic                r_ren;
  logic                r_bit;
  logic                r_vld;
  logic                r_busy;
  logic                r_done;

  logic                w_b;
  logic [7:0]          w_pred;
  logic                w_last;
  logic                w_nbit;

  // Survivor bit selects the MSB of the predecessor state.
  assign w_b    = tb.DataRAM[r_state[2:0]];
  assign w_pred = {w_b, r_state[7:1]};
  assign w_last = (r_cnt == 7'(WALK - 1));

  assign tb.AddressRAM   = r_addr;
  assign tb.RAMEnable    = r_ren;
  assign tb.RWSelect     = 1'b1;
  assign tb.DecodedBit   = r_bit;
  assign tb.DecodedValid = r_vld;
  assign tb.TbBusy       = r_busy;
  assign tb.TbDone       = r_done;

  always_ff @(posedge i_Clock1 or negedge i_Reset) begin
    if (!i_Reset) r_fsm <= S_IDLE;
    else          r_fsm <= w_nxt;
  end

  always_comb begin
    w_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (tb.TbStart) w_nxt = S_RD;
      S_RD:    w_nxt = S_CAP;
      S_CAP:   w_nxt = w_last ? S_OUT : S_RD;
      S_OUT:   if (r_idx == 6'd0) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Next bit to present while draining: buf[idx-1].
  always_comb begin
    w_nbit = 1'b0;
    for (int j = 0; j < DEC_LEN - 1; j++)
      if (r_idx == 6'(j + 1)) w_nbit = r_buf[j];
  end

  always_ff @(posedge i_Clock1 or negedge i_Reset) begin
    if (!i_Reset) begin
      r_stage <= '0;
      r_state <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (tb.TbStart) begin
          r_stage <= tb.TbStartStage;
          r_state <= tb.TbStartState;
          r_cnt   <= '0;
        end
        S_CAP: begin
          // Decision of this stage is state[0]; only the last DEC_LEN are kept.
          for (int j = 0; j < DEC_LEN; j++)
            if (r_cnt == 7'(TB_LEN + j)) r_buf[j] <= r_state[0];
          r_state <= w_pred;
          r_stage <= r_stage - 6'd1;
          r_cnt   <= r_cnt + 7'd1;
          if (w_last) r_idx <= 6'(DEC_LEN - 1);
        end
        S_OUT: if (r_idx != 6'd0) r_idx <= r_idx - 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clock1 or negedge i_Reset) begin
    if (!i_Reset) begin
      r_addr <= '0;
      r_ren  <= 1'b1;
      r_bit  <= 1'b0;
      r_vld  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ren  <= !(w_nxt == S_RD || w_nxt == S_CAP);
      r_busy <= (w_nxt == S_RD) || (w_nxt == S_CAP) || (w_nxt == S_OUT);
      r_vld  <= (w_nxt == S_OUT);
      r_done <= (w_nxt == S_DONE);
      // Address is computed from the next stage/state so it is on the bus
      // during RD and held through CAP.
      if (r_fsm == S_IDLE && w_nxt == S_RD)
        r_addr <= {tb.TbStartStage, tb.TbStartState[7:3]};
      else if (r_fsm == S_CAP && w_nxt == S_RD)
        r_addr <= {r_stage - 6'd1, w_pred[7:3]};
      // First output is the bit captured in the final CAP, which is not yet
      // in the buffer, so it is taken straight from the state register.
      if (r_fsm == S_CAP && w_nxt == S_OUT)
        r_bit <= r_state[0];
      else if (r_fsm == S_OUT && w_nxt == S_OUT)
        r_bit <= w_nbit;
    end
  end

endmodule
